// File: rtl/mux_4_1_sync_pkg.sv
// Shared select-code encodings for the 4-to-1 word multiplexer.
// Datapath control logic imports these so that both sides decode sel the same way.
package mux_4_1_sync_pkg;

  localparam int unsigned SEL_W = 2;

  typedef logic [0:SEL_W-1] sel_t;

  localparam sel_t SEL_A0 = 2'd0;
  localparam sel_t SEL_A1 = 2'd1;
  localparam sel_t SEL_A2 = 2'd2;
  localparam sel_t SEL_A3 = 2'd3;

endpackage : mux_4_1_sync_pkg

// File: rtl/pipe_reg_sync.sv
// Generic WIDTH-bit pipeline register with synchronous active-high reset.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous reset, active-high; clears q to all zeros
//   d   - next value, loaded every edge when rst=0
//   q   - registered value
module pipe_reg_sync #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] d,
  output logic [0:WIDTH-1] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : pipe_reg_sync

// File: rtl/mux_4_1_sync.sv
// 4-to-1 word multiplexer with enable and optional registered output.
// Ports:
//   clk    - clock, used only when OUT_REG=1
//   rst    - synchronous active-high reset, used only when OUT_REG=1
//   a0..a3 - data inputs selected by sel = 0..3
//   sel    - unsigned select code, bit 0 is the MSB
//   enb    - enable; when 0 the selected value is forced to zero
//   y      - selected data (combinational when OUT_REG=0, one-cycle registered when OUT_REG=1)
module mux_4_1_sync
  import mux_4_1_sync_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] a0,
  input  logic [0:WIDTH-1] a1,
  input  logic [0:WIDTH-1] a2,
  input  logic [0:WIDTH-1] a3,
  input  logic [0:SEL_W-1] sel,
  input  logic             enb,
  output logic [0:WIDTH-1] y
);

  logic [0:WIDTH-1] sel_val;
  logic [0:WIDTH-1] v;

  // Compare chain rather than a defaulted case so an unknown sel propagates X
  // instead of silently picking a0.
  assign sel_val = (sel == SEL_A3) ? a3 :
                   (sel == SEL_A2) ? a2 :
                   (sel == SEL_A1) ? a1 : a0;

  assign v = enb ? sel_val : '0;

  generate
    if (OUT_REG == 1) begin : g_out_reg
      pipe_reg_sync #(
        .WIDTH (WIDTH)
      ) u_out_reg (
        .clk (clk),
        .rst (rst),
        .d   (v),
        .q   (y)
      );
    end else begin : g_out_comb
      // clk/rst are deliberately ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign y = v;
    end
  endgenerate

endmodule : mux_4_1_sync

// File: tb/tb_mux_4_1_sync.sv
// Self-checking bench for mux_4_1_sync: one combinational and one registered instance
// share the same stimulus and are compared against a behavioural reference model.
module tb_mux_4_1_sync;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [0:WIDTH-1] a0, a1, a2, a3;
  logic [0:1]       sel;
  logic             enb;
  logic [0:WIDTH-1] y_c;
  logic [0:WIDTH-1] y_r;

  logic [0:WIDTH-1] exp_r;
  int checks;
  int errors;

  mux_4_1_sync #(.WIDTH(WIDTH), .OUT_REG(0)) dut_comb (
    .clk (clk), .rst (rst),
    .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3),
    .sel (sel), .enb (enb), .y (y_c)
  );

  mux_4_1_sync #(.WIDTH(WIDTH), .OUT_REG(1)) dut_reg (
    .clk (clk), .rst (rst),
    .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3),
    .sel (sel), .enb (enb), .y (y_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick the word by numeric select, zero when disabled.
  function automatic logic [0:WIDTH-1] ref_v();
    logic [0:WIDTH-1] words [4];
    words[0] = a0;
    words[1] = a1;
    words[2] = a2;
    words[3] = a3;
    if (!enb) return '0;
    return words[int'(sel)];
  endfunction

  function automatic logic [0:WIDTH-1] pattern(input int idx);
    logic [0:WIDTH-1] tab [4];
    tab[0] = 32'h00010101;
    tab[1] = 32'h00020202;
    tab[2] = 32'h00030303;
    tab[3] = 32'h00040404;
    return tab[idx];
  endfunction

  // Advance one clock; the model register takes what the DUT register should take.
  task automatic tick();
    logic [0:WIDTH-1] nxt;
    nxt = rst ? '0 : ref_v();
    @(posedge clk);
    exp_r = nxt;
    #1;
  endtask

  task automatic load_patterns();
    a0 = pattern(0);
    a1 = pattern(1);
    a2 = pattern(2);
    a3 = pattern(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enb = 1'b1;
    sel = 2'd1;
    load_patterns();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (y_r !== 32'h0) begin
        $display("FAIL reset_cycle%0d y=%h expected=%h", i, y_r, 32'h0);
        errors++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep();
    load_patterns();
    enb = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (y_c !== pattern(s)) begin
        $display("FAIL comb_sweep sel=%0d y=%h expected=%h", s, y_c, pattern(s));
        errors++;
      end
      #9;
    end
  endtask

  task automatic test_comb_enable();
    enb = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (y_c !== 32'h0) begin
        $display("FAIL comb_disabled sel=%0d y=%h expected=%h", s, y_c, 32'h0);
        errors++;
      end
      #9;
    end
    enb = 1'b1;
    sel = 2'd2;
    #1;
    checks++;
    if (y_c !== 32'h00030303) begin
      $display("FAIL comb_reenable y=%h expected=%h", y_c, 32'h00030303);
      errors++;
    end
    #9;
  endtask

  task automatic test_comb_follow();
    sel = 2'd1;
    enb = 1'b1;
    a1  = 32'hDEADBEEF;
    #1;
    checks++;
    if (y_c !== 32'hDEADBEEF) begin
      $display("FAIL comb_follow_a1 y=%h expected=%h", y_c, 32'hDEADBEEF);
      errors++;
    end
    a0 = 32'h12345678;
    #1;
    checks++;
    if (y_c !== 32'hDEADBEEF) begin
      $display("FAIL comb_ignore_a0 y=%h expected=%h", y_c, 32'hDEADBEEF);
      errors++;
    end
    #8;
  endtask

  task automatic test_reg_latency();
    load_patterns();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (y_r !== 32'h0) begin
      $display("FAIL reg_reset y=%h expected=%h", y_r, 32'h0);
      errors++;
    end
    rst = 1'b0;
    sel = 2'd3;
    enb = 1'b1;
    #1;
    checks++;
    if (y_r !== 32'h0) begin
      $display("FAIL reg_before_edge y=%h expected=%h", y_r, 32'h0);
      errors++;
    end
    tick();
    checks++;
    if (y_r !== 32'h00040404) begin
      $display("FAIL reg_one_cycle y=%h expected=%h", y_r, 32'h00040404);
      errors++;
    end
  endtask

  task automatic test_reg_stream();
    load_patterns();
    enb = 1'b1;
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      checks++;
      if (y_r !== pattern(s)) begin
        $display("FAIL reg_stream sel=%0d y=%h expected=%h", s, y_r, pattern(s));
        errors++;
      end
    end
  endtask

  task automatic test_reg_reset_priority();
    load_patterns();
    rst = 1'b1;
    enb = 1'b1;
    sel = 2'd2;
    tick();
    checks++;
    if (y_r !== 32'h0) begin
      $display("FAIL reg_reset_priority y=%h expected=%h", y_r, 32'h0);
      errors++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (y_r !== 32'h00030303) begin
      $display("FAIL reg_post_reset y=%h expected=%h", y_r, 32'h00030303);
      errors++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      a0  = $urandom;
      a1  = $urandom;
      a2  = $urandom;
      a3  = $urandom;
      sel = 2'($urandom_range(3, 0));
      enb = ($urandom_range(3, 0) != 0);
      rst = ($urandom_range(7, 0) == 0);
      #1;
      checks++;
      if (y_c !== ref_v()) begin
        $display("FAIL rand_comb iter=%0d y=%h expected=%h", i, y_c, ref_v());
        errors++;
      end
      tick();
      checks++;
      if (y_r !== exp_r) begin
        $display("FAIL rand_reg iter=%0d y=%h expected=%h", i, y_r, exp_r);
        errors++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_r  = '0;
    rst    = 1'b1;
    enb    = 1'b0;
    sel    = 2'd0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_comb_sweep();
    test_comb_enable();
    test_comb_follow();
    test_reg_latency();
    test_reg_stream();
    test_reg_reset_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_4_1_sync

// File: doc/mux_4_1_sync.md
Name: mux_4_1_sync

Overview:
- Generic 4-to-1 word multiplexer with an enable.
- Used throughout the VCPU-32 datapath to select operands, results and address sources.
- Default build is a pure combinational path, so existing instantiations that drive only a0..a3, sel, enb and y keep working.
- An optional output register stage gives a one-cycle registered variant for pipeline-stage boundaries.

Parameters:
- WIDTH, 32, data width of a0..a3 and y. Big-endian bit numbering [0:WIDTH-1].
- OUT_REG, 0, output mode:
  - 0 = combinational output.
  - 1 = y registered on the rising edge of clk.

Ports:
- clk  input  1  system clock. Used only when OUT_REG=1. Tie-off is allowed when OUT_REG=0.
- rst  input  1  reset, synchronous, active-high. Used only when OUT_REG=1.
- a0  input  WIDTH  data input selected by sel=0.
- a1  input  WIDTH  data input selected by sel=1.
- a2  input  WIDTH  data input selected by sel=2.
- a3  input  WIDTH  data input selected by sel=3.
- sel  input  2 ([0:1])  select code, unsigned: 0..3 maps to a0..a3.
- enb  input  1  enable. When 0, the output value is all zeros.
- y  output  WIDTH  selected data.

Behaviour:
- Selected value is v = enb ? a[sel] : 0.
  - a[sel] is a0/a1/a2/a3 for sel = 0/1/2/3.
  - Every 2-bit sel code is decoded; there is no illegal code.
  - sel containing X/Z in simulation yields y = X. There is no silent default to a0.
- OUT_REG=0:
  - y = v, purely combinational, zero latency.
  - y follows any input change within the same delta/timestep.
  - clk and rst have no effect.
- OUT_REG=1:
  - y is a register. At each rising clk edge: if rst=1 then y <= 0, else y <= v.
  - Latency is exactly one cycle from a sel/data/enb change to y.
  - Reset value of y is all zeros. Reset wins over enb and sel in the same cycle.
  - rst asserted mid-stream clears y at the next edge. The first post-reset edge loads the v present at that edge.
  - Before the first clock edge y is X. A bench must reset first.
- No internal state besides the optional output register. No handshake; y is valid at all times (OUT_REG=0) or one cycle after the input (OUT_REG=1).
- Width rules:
  - Inputs and output are the same WIDTH, with no extension or truncation.
  - Bit 0 is the MSB, matching the codebase convention.
- Must synthesize to a LUT/AND-OR mux. No latches in the OUT_REG=0 build.

Decomposition:
- No dedicated package is required.
- Select-code constants (SEL_A0..SEL_A3 = 2'd0..2'd3) belong in the shared VCPU32 definitions header so datapath control logic and this block share encodings.
- One optional sub-module is natural: a generic WIDTH-bit synchronous-reset register, pipe_reg_sync (clk, rst, d, q).
  - Instantiate it under a generate on OUT_REG=1.
  - The same register is reused by other stage-boundary blocks.
- The mux core stays inline.

Test Plan:
1. OUT_REG=0, WIDTH=32, a0=0x00010101, a1=0x00020202, a2=0x00030303, a3=0x00040404, enb=1, sweep sel 0,1,2,3 with 10 time units each → y = 0x00010101, 0x00020202, 0x00030303, 0x00040404 respectively.
2. OUT_REG=0, same data, enb=0, all four sel values → y = 0x00000000 each time. Re-assert enb=1 with sel=2 → y = 0x00030303 immediately.
3. OUT_REG=0, sel=1 held, change a1 to 0xDEADBEEF → y = 0xDEADBEEF in the same timestep. Change a0 → y unchanged.
4. OUT_REG=1:
   - Assert rst for 2 cycles → y = 0.
   - Release rst, sel=3, enb=1 → y = 0x00040404 after exactly one rising edge; y stays 0 on the cycle the input is applied.
5. OUT_REG=1, streaming sel=0,1,2,3 one per cycle → y follows one cycle late: 0x00010101, 0x00020202, 0x00030303, 0x00040404.
6. OUT_REG=1, rst=1 and enb=1, sel=2 at the same edge → y = 0 (reset priority). Next edge with rst=0 → y = 0x00030303.
